// File: rtl/icache_axi_refill_fsm_if.sv
// Bundle of the icache request/return port and the AXI4 read channels (AR, R)
// used by icache_axi_refill_fsm; master is the refill FSM side.
interface icache_axi_refill_fsm_if #(
    parameter int LineWidth  = 128,
    parameter int AddrWidth  = 64,
    parameter int AxiIdWidth = 4,
    parameter int TidWidth   = 2
);
    logic                  req_i;
    logic                  gnt_o;
    logic [AddrWidth-1:0]  addr_i;
    logic                  nc_i;
    logic [TidWidth-1:0]   tid_i;

    logic                  ar_valid_o;
    logic                  ar_ready_i;
    logic [AddrWidth-1:0]  ar_addr_o;
    logic [7:0]            ar_len_o;
    logic [2:0]            ar_size_o;
    logic [1:0]            ar_burst_o;
    logic [AxiIdWidth-1:0] ar_id_o;

    logic                  r_valid_i;
    logic                  r_ready_o;
    logic [63:0]           r_data_i;
    logic                  r_last_i;
    logic [1:0]            r_resp_i;

    logic                  rtrn_vld_o;
    logic [LineWidth-1:0]  rtrn_data_o;
    logic [TidWidth-1:0]   rtrn_tid_o;
    logic                  rtrn_err_o;

    modport master (
        input  req_i, addr_i, nc_i, tid_i,
        input  ar_ready_i,
        input  r_valid_i, r_data_i, r_last_i, r_resp_i,
        output gnt_o,
        output ar_valid_o, ar_addr_o, ar_len_o, ar_size_o, ar_burst_o, ar_id_o,
        output r_ready_o,
        output rtrn_vld_o, rtrn_data_o, rtrn_tid_o, rtrn_err_o
    );

    modport slave (
        output req_i, addr_i, nc_i, tid_i,
        output ar_ready_i,
        output r_valid_i, r_data_i, r_last_i, r_resp_i,
        input  gnt_o,
        input  ar_valid_o, ar_addr_o, ar_len_o, ar_size_o, ar_burst_o, ar_id_o,
        input  r_ready_o,
        input  rtrn_vld_o, rtrn_data_o, rtrn_tid_o, rtrn_err_o
    );
endinterface

// File: rtl/icache_axi_refill_fsm.sv
// AXI4 read master for L1I$ line refills and non-cacheable bypass reads.
// Define ICACHE_REFILL_CRITWORD_EN for critical-word-first WRAP refills.
module icache_axi_refill_fsm #(
    parameter int          LineWidth  = 128,
    parameter int          AddrWidth  = 64,
    parameter int          AxiIdWidth = 4,
    parameter int          TidWidth   = 2,
    parameter int unsigned AxiId      = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clr_i,
    icache_axi_refill_fsm_if.master bus
);
    localparam int NumWords = LineWidth / 64;
    localparam int CntW     = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam int OffW     = $clog2(LineWidth / 8);

    localparam logic [CntW-1:0]      LastIdx   = CntW'(NumWords - 1);
    localparam logic [CntW:0]        NumWordsW = (CntW + 1)'(NumWords);
    localparam logic [AddrWidth-1:0] LineMask  = AddrWidth'(LineWidth / 8 - 1);
    localparam logic [AddrWidth-1:0] WordMask  = AddrWidth'(7);
    localparam logic [1:0]           BurstIncr = 2'b01;
    localparam logic [1:0]           BurstWrap = 2'b10;

    typedef enum logic [1:0] {IDLE, AR, RD, RTRN} state_e;

    state_e                         state_q, state_d;
    logic                           gnt;
    logic [AddrWidth-1:0]           addr_q;
    logic                           nc_q;
    logic [TidWidth-1:0]            tid_q;
    logic [CntW-1:0]                cnt_q, cnt_inc, exp_last, start_idx, word_idx;
    logic [CntW:0]                  idx_sum;
    logic                           err_q, err_d;
    logic [NumWords-1:0][63:0]      line_q, line_d;
    logic [LineWidth-1:0]           rtrn_data_q;
    logic [TidWidth-1:0]            rtrn_tid_q;
    logic                           rtrn_err_q;
    logic                           beat;
    logic                           resp_err;
    logic [AddrWidth-1:0]           ar_addr_d;
    logic [1:0]                     ar_burst_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else if (clr_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req_i) state_d = AR;
            AR:      if (bus.ar_ready_i) state_d = RD;
            RD:      if (bus.r_valid_i && bus.r_last_i) state_d = RTRN;
            RTRN:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bypass reads are always one 8-byte beat; refills start at the line base
    // or, with critical-word-first, at the requested word.
`ifdef ICACHE_REFILL_CRITWORD_EN
    assign ar_addr_d  = addr_q & ~WordMask;
    assign ar_burst_d = nc_q ? BurstIncr : BurstWrap;
    if (NumWords > 1) begin : g_start
        assign start_idx = addr_q[OffW-1:3];
    end else begin : g_start_single
        assign start_idx = '0;
    end
`else
    assign ar_addr_d  = nc_q ? (addr_q & ~WordMask) : (addr_q & ~LineMask);
    assign ar_burst_d = BurstIncr;
    assign start_idx  = '0;
`endif

    always_comb begin
        gnt            = 1'b0;
        bus.ar_valid_o = 1'b0;
        bus.ar_addr_o  = '0;
        bus.ar_len_o   = '0;
        bus.ar_burst_o = '0;
        bus.r_ready_o  = 1'b0;
        bus.rtrn_vld_o = 1'b0;
        case (state_q)
            IDLE: gnt = bus.req_i & ~clr_i;
            AR: begin
                bus.ar_valid_o = 1'b1;
                bus.ar_addr_o  = ar_addr_d;
                bus.ar_len_o   = nc_q ? 8'd0 : 8'(NumWords - 1);
                bus.ar_burst_o = ar_burst_d;
            end
            RD:      bus.r_ready_o  = 1'b1;
            RTRN:    bus.rtrn_vld_o = 1'b1;
            default: ;
        endcase
    end

    assign bus.gnt_o       = gnt;
    assign bus.ar_size_o   = 3'b011;
    assign bus.ar_id_o     = AxiIdWidth'(AxiId);
    assign bus.rtrn_data_o = rtrn_data_q;
    assign bus.rtrn_tid_o  = rtrn_tid_q;
    assign bus.rtrn_err_o  = rtrn_err_q;

    assign beat     = (state_q == RD) && bus.r_valid_i;
    assign resp_err = bus.r_resp_i inside {2'b10, 2'b11};
    assign exp_last = nc_q ? '0 : LastIdx;
    assign cnt_inc  = (cnt_q == LastIdx) ? '0 : cnt_q + 1'b1;
    assign idx_sum  = {1'b0, start_idx} + {1'b0, cnt_q};

    // Protocol errors (too many beats, early last) fold into the sticky error.
    always_comb begin
        line_d   = line_q;
        word_idx = CntW'(idx_sum);
        if (nc_q) begin
            word_idx = '0;
        end else if (idx_sum >= NumWordsW) begin
            word_idx = CntW'(idx_sum - NumWordsW);
        end
        if (beat) begin
            line_d[word_idx] = bus.r_data_i;
        end
        err_d = err_q;
        if (beat) begin
            err_d = err_q | resp_err
                  | (!bus.r_last_i && cnt_q == exp_last)
                  | (bus.r_last_i && cnt_q != exp_last);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q      <= '0;
            nc_q        <= 1'b0;
            tid_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            line_q      <= '0;
            rtrn_data_q <= '0;
            rtrn_tid_q  <= '0;
            rtrn_err_q  <= 1'b0;
        end else if (clr_i) begin
            addr_q      <= '0;
            nc_q        <= 1'b0;
            tid_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            line_q      <= '0;
            rtrn_data_q <= '0;
            rtrn_tid_q  <= '0;
            rtrn_err_q  <= 1'b0;
        end else begin
            if (gnt) begin
                addr_q <= bus.addr_i;
                nc_q   <= bus.nc_i;
                tid_q  <= bus.tid_i;
                err_q  <= 1'b0;
            end
            if (state_q == AR && bus.ar_ready_i) begin
                cnt_q <= '0;
            end
            if (beat) begin
                line_q <= line_d;
                cnt_q  <= cnt_inc;
                err_q  <= err_d;
                if (bus.r_last_i) begin
                    rtrn_data_q <= line_d;
                    rtrn_tid_q  <= tid_q;
                    rtrn_err_q  <= err_d;
                end
            end
        end
    end
endmodule

// File: tb/tb_icache_axi_refill_fsm.sv
// Directed bench for icache_axi_refill_fsm with a 128-bit line; expectations
// follow the build selected by ICACHE_REFILL_CRITWORD_EN.
module tb_icache_axi_refill_fsm;
    localparam int LineWidth  = 128;
    localparam int AddrWidth  = 64;
    localparam int AxiIdWidth = 4;
    localparam int TidWidth   = 2;

`ifdef ICACHE_REFILL_CRITWORD_EN
    localparam logic [63:0] ExpCacheAddr  = 64'h8000_0018;
    localparam logic [1:0]  ExpCacheBurst = 2'b10;
`else
    localparam logic [63:0] ExpCacheAddr  = 64'h8000_0010;
    localparam logic [1:0]  ExpCacheBurst = 2'b01;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic clr;
    int   checks = 0;
    int   errors = 0;
    logic [127:0] exp_line;
    logic         g;

    always #5 clk = ~clk;

    icache_axi_refill_fsm_if #(
        .LineWidth(LineWidth), .AddrWidth(AddrWidth),
        .AxiIdWidth(AxiIdWidth), .TidWidth(TidWidth)
    ) bus ();

    icache_axi_refill_fsm #(
        .LineWidth(LineWidth), .AddrWidth(AddrWidth),
        .AxiIdWidth(AxiIdWidth), .TidWidth(TidWidth), .AxiId(0)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .clr_i (clr),
        .bus   (bus)
    );

    task automatic issue_req(input logic [63:0] addr, input logic nc,
                             input logic [1:0] tid, output logic gnt_seen);
        bus.req_i  = 1'b1;
        bus.addr_i = addr;
        bus.nc_i   = nc;
        bus.tid_i  = tid;
        #1 gnt_seen = bus.gnt_o;
        @(negedge clk);
        bus.req_i = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] data, input logic last, input logic [1:0] resp);
        bus.r_valid_i = 1'b1;
        bus.r_data_i  = data;
        bus.r_last_i  = last;
        bus.r_resp_i  = resp;
        @(negedge clk);
        bus.r_valid_i = 1'b0;
        bus.r_last_i  = 1'b0;
        bus.r_resp_i  = 2'b00;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.gnt_o, bus.ar_valid_o, bus.ar_addr_o, bus.ar_len_o, bus.ar_burst_o,
             bus.r_ready_o, bus.rtrn_vld_o, bus.rtrn_tid_o, bus.rtrn_err_o} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got ar_valid=%b ar_addr=%h r_ready=%b rtrn_vld=%b expected all 0",
                     bus.ar_valid_o, bus.ar_addr_o, bus.r_ready_o, bus.rtrn_vld_o);
        end
        checks++;
        if ({bus.ar_size_o, bus.ar_id_o, bus.rtrn_data_o} !== {3'b011, 4'd0, 128'd0}) begin
            errors++;
            $display("[TB] FAIL reset_const: got size=%0d id=%0d data=%h expected size=3 id=0 data=0",
                     bus.ar_size_o, bus.ar_id_o, bus.rtrn_data_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_clear;
        bus.req_i = 1'b1;
        clr       = 1'b1;
        #1;
        checks++;
        if (bus.gnt_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clr_gnt: got %b expected 0", bus.gnt_o);
        end
        @(negedge clk);
        bus.req_i = 1'b0;
        clr       = 1'b0;
        issue_req(64'h7000_0000, 1'b0, 2'd0, g);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        #1;
        checks++;
        if ({bus.ar_valid_o, bus.r_ready_o, bus.rtrn_vld_o} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL clr_abort: got ar_valid=%b r_ready=%b rtrn_vld=%b expected 000",
                     bus.ar_valid_o, bus.r_ready_o, bus.rtrn_vld_o);
        end
        @(negedge clk);
        exp_line = '0;
    endtask

    task automatic test_cacheable;
        issue_req(64'h8000_0018, 1'b0, 2'd2, g);
        checks++;
        if (g !== 1'b1) begin
            errors++;
            $display("[TB] FAIL cache_gnt: got %b expected 1", g);
        end
        checks++;
        if ({bus.ar_valid_o, bus.ar_addr_o, bus.ar_len_o, bus.ar_burst_o} !==
            {1'b1, ExpCacheAddr, 8'd1, ExpCacheBurst}) begin
            errors++;
            $display("[TB] FAIL cache_ar: got valid=%b addr=%h len=%0d burst=%b expected 1 %h 1 %b",
                     bus.ar_valid_o, bus.ar_addr_o, bus.ar_len_o, bus.ar_burst_o, ExpCacheAddr, ExpCacheBurst);
        end
        @(negedge clk);
        checks++;
        if ({bus.r_ready_o, bus.ar_valid_o} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL cache_rd_state: got r_ready=%b ar_valid=%b expected 1 0",
                     bus.r_ready_o, bus.ar_valid_o);
        end
`ifdef ICACHE_REFILL_CRITWORD_EN
        send_beat(64'hB, 1'b0, 2'b00);
        send_beat(64'hA, 1'b1, 2'b00);
`else
        send_beat(64'hA, 1'b0, 2'b00);
        send_beat(64'hB, 1'b1, 2'b00);
`endif
        exp_line = {64'hB, 64'hA};
        checks++;
        if ({bus.rtrn_vld_o, bus.rtrn_data_o, bus.rtrn_tid_o, bus.rtrn_err_o, bus.r_ready_o} !==
            {1'b1, exp_line, 2'd2, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL cache_rtrn: got vld=%b data=%h tid=%0d err=%b expected 1 %h 2 0",
                     bus.rtrn_vld_o, bus.rtrn_data_o, bus.rtrn_tid_o, bus.rtrn_err_o, exp_line);
        end
        @(negedge clk);
        checks++;
        if ({bus.rtrn_vld_o, bus.rtrn_data_o, bus.rtrn_tid_o} !== {1'b0, exp_line, 2'd2}) begin
            errors++;
            $display("[TB] FAIL cache_hold: got vld=%b data=%h tid=%0d expected 0 %h 2",
                     bus.rtrn_vld_o, bus.rtrn_data_o, bus.rtrn_tid_o, exp_line);
        end
    endtask

    task automatic test_nc;
        issue_req(64'h1000_0004, 1'b1, 2'd1, g);
        checks++;
        if ({g, bus.ar_valid_o, bus.ar_addr_o, bus.ar_len_o, bus.ar_burst_o} !==
            {1'b1, 1'b1, 64'h1000_0000, 8'd0, 2'b01}) begin
            errors++;
            $display("[TB] FAIL nc_ar: got gnt=%b valid=%b addr=%h len=%0d burst=%b expected 1 1 10000000 0 01",
                     g, bus.ar_valid_o, bus.ar_addr_o, bus.ar_len_o, bus.ar_burst_o);
        end
        @(negedge clk);
        send_beat(64'h55, 1'b1, 2'b00);
        exp_line[63:0] = 64'h55;
        checks++;
        if ({bus.rtrn_vld_o, bus.rtrn_data_o, bus.rtrn_tid_o, bus.rtrn_err_o} !==
            {1'b1, exp_line, 2'd1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL nc_rtrn: got vld=%b data=%h tid=%0d err=%b expected 1 %h 1 0",
                     bus.rtrn_vld_o, bus.rtrn_data_o, bus.rtrn_tid_o, bus.rtrn_err_o, exp_line);
        end
        @(negedge clk);
    endtask

    task automatic test_ar_stall;
        bus.ar_ready_i = 1'b0;
        issue_req(64'h2000_0040, 1'b0, 2'd1, g);
        for (int i = 0; i < 5; i++) begin
            bus.req_i  = 1'b1;
            bus.addr_i = 64'hDEAD_BEE8;
            #1;
            checks++;
            if ({bus.gnt_o, bus.ar_valid_o, bus.ar_addr_o, bus.ar_len_o, bus.ar_burst_o} !==
                {1'b0, 1'b1, 64'h2000_0040, 8'd1, ExpCacheBurst}) begin
                errors++;
                $display("[TB] FAIL stall_ar_%0d: got gnt=%b valid=%b addr=%h len=%0d burst=%b expected 0 1 20000040 1 %b",
                         i, bus.gnt_o, bus.ar_valid_o, bus.ar_addr_o, bus.ar_len_o, bus.ar_burst_o, ExpCacheBurst);
            end
            @(negedge clk);
        end
        bus.req_i      = 1'b0;
        bus.ar_ready_i = 1'b1;
        @(negedge clk);
        send_beat(64'h11, 1'b0, 2'b00);
        send_beat(64'h22, 1'b1, 2'b00);
        exp_line = {64'h22, 64'h11};
        bus.req_i = 1'b1;
        #1;
        checks++;
        if ({bus.gnt_o, bus.rtrn_vld_o, bus.rtrn_data_o, bus.rtrn_tid_o, bus.rtrn_err_o} !==
            {1'b0, 1'b1, exp_line, 2'd1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL stall_rtrn: got gnt=%b vld=%b data=%h tid=%0d err=%b expected 0 1 %h 1 0",
                     bus.gnt_o, bus.rtrn_vld_o, bus.rtrn_data_o, bus.rtrn_tid_o, bus.rtrn_err_o, exp_line);
        end
        bus.req_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_error;
        issue_req(64'h3000_0000, 1'b0, 2'd3, g);
        @(negedge clk);
        send_beat(64'h1, 1'b0, 2'b00);
        send_beat(64'h2, 1'b1, 2'b10);
        exp_line = {64'h2, 64'h1};
        checks++;
        if ({bus.rtrn_vld_o, bus.rtrn_data_o, bus.rtrn_tid_o, bus.rtrn_err_o} !==
            {1'b1, exp_line, 2'd3, 1'b1}) begin
            errors++;
            $display("[TB] FAIL err_slverr: got vld=%b data=%h tid=%0d err=%b expected 1 %h 3 1",
                     bus.rtrn_vld_o, bus.rtrn_data_o, bus.rtrn_tid_o, bus.rtrn_err_o, exp_line);
        end
        @(negedge clk);
        issue_req(64'h3000_0010, 1'b0, 2'd0, g);
        @(negedge clk);
        send_beat(64'h3, 1'b0, 2'b00);
        send_beat(64'h4, 1'b1, 2'b00);
        exp_line = {64'h4, 64'h3};
        checks++;
        if ({bus.rtrn_vld_o, bus.rtrn_data_o, bus.rtrn_tid_o, bus.rtrn_err_o} !==
            {1'b1, exp_line, 2'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL err_cleared: got vld=%b data=%h tid=%0d err=%b expected 1 %h 0 0",
                     bus.rtrn_vld_o, bus.rtrn_data_o, bus.rtrn_tid_o, bus.rtrn_err_o, exp_line);
        end
        @(negedge clk);
    endtask

    task automatic test_early_last;
        issue_req(64'h4000_0000, 1'b0, 2'd1, g);
        @(negedge clk);
        send_beat(64'h77, 1'b1, 2'b00);
        exp_line[63:0] = 64'h77;
        checks++;
        if ({bus.rtrn_vld_o, bus.rtrn_data_o, bus.rtrn_err_o} !== {1'b1, exp_line, 1'b1}) begin
            errors++;
            $display("[TB] FAIL early_last: got vld=%b data=%h err=%b expected 1 %h 1",
                     bus.rtrn_vld_o, bus.rtrn_data_o, bus.rtrn_err_o, exp_line);
        end
        @(negedge clk);
    endtask

    task automatic test_overflow;
        issue_req(64'h5000_0000, 1'b0, 2'd2, g);
        @(negedge clk);
        send_beat(64'h10, 1'b0, 2'b00);
        send_beat(64'h20, 1'b0, 2'b00);
        send_beat(64'h30, 1'b1, 2'b00);
        exp_line = {64'h20, 64'h30};
        checks++;
        if ({bus.rtrn_vld_o, bus.rtrn_data_o, bus.rtrn_err_o} !== {1'b1, exp_line, 1'b1}) begin
            errors++;
            $display("[TB] FAIL overflow: got vld=%b data=%h err=%b expected 1 %h 1",
                     bus.rtrn_vld_o, bus.rtrn_data_o, bus.rtrn_err_o, exp_line);
        end
        @(negedge clk);
    endtask

    task automatic test_mid_reset;
        issue_req(64'h6000_0000, 1'b0, 2'd3, g);
        @(negedge clk);
        send_beat(64'h99, 1'b0, 2'b00);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.ar_valid_o, bus.r_ready_o, bus.rtrn_vld_o, bus.rtrn_data_o,
             bus.rtrn_tid_o, bus.rtrn_err_o} !== '0) begin
            errors++;
            $display("[TB] FAIL midrst_out: got ar_valid=%b r_ready=%b vld=%b data=%h tid=%0d err=%b expected all 0",
                     bus.ar_valid_o, bus.r_ready_o, bus.rtrn_vld_o, bus.rtrn_data_o,
                     bus.rtrn_tid_o, bus.rtrn_err_o);
        end
        exp_line = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.rtrn_vld_o !== 1'b0) begin
                errors++;
                $display("[TB] FAIL midrst_no_rtrn_%0d: got %b expected 0", i, bus.rtrn_vld_o);
            end
        end
        issue_req(64'h6000_0008, 1'b1, 2'd2, g);
        checks++;
        if ({g, bus.ar_valid_o, bus.ar_addr_o, bus.ar_len_o, bus.ar_burst_o} !==
            {1'b1, 1'b1, 64'h6000_0008, 8'd0, 2'b01}) begin
            errors++;
            $display("[TB] FAIL midrst_ar: got gnt=%b valid=%b addr=%h len=%0d burst=%b expected 1 1 60000008 0 01",
                     g, bus.ar_valid_o, bus.ar_addr_o, bus.ar_len_o, bus.ar_burst_o);
        end
        @(negedge clk);
        send_beat(64'hAB, 1'b1, 2'b00);
        exp_line[63:0] = 64'hAB;
        checks++;
        if ({bus.rtrn_vld_o, bus.rtrn_data_o, bus.rtrn_tid_o, bus.rtrn_err_o} !==
            {1'b1, exp_line, 2'd2, 1'b0}) begin
            errors++;
            $display("[TB] FAIL midrst_rtrn: got vld=%b data=%h tid=%0d err=%b expected 1 %h 2 0",
                     bus.rtrn_vld_o, bus.rtrn_data_o, bus.rtrn_tid_o, bus.rtrn_err_o, exp_line);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n          = 1'b0;
        clr            = 1'b0;
        bus.req_i      = 1'b0;
        bus.addr_i     = '0;
        bus.nc_i       = 1'b0;
        bus.tid_i      = '0;
        bus.ar_ready_i = 1'b1;
        bus.r_valid_i  = 1'b0;
        bus.r_data_i   = '0;
        bus.r_last_i   = 1'b0;
        bus.r_resp_i   = 2'b00;
        exp_line       = '0;

        test_reset();
        test_clear();
        test_cacheable();
        test_nc();
        test_ar_stall();
        test_error();
        test_early_last();
        test_overflow();
        test_mid_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
